conv_allocator: RTL and testbench

- Receiving end of the Issue broadcast/positioner protocol; one instance per allocator slot, driven by its own bit of positioner_select.
- When selected, it latches a window centre and gathers the (2h+1)x(2h+1) pixel window from the shared broadcast bus, one channel pass at a time.
- It presents each full window to the downstream MAC over a ready/valid stream.
- While its window buffer is occupied, it back-pressures Issue through issue_block.

---
 rtl/conv_allocator_pkg.sv | 19 +
 rtl/conv_alloc_bounds.sv | 45 ++++
 rtl/conv_allocator.sv | 207 ++++++++++++++++++++
 tb/tb_conv_allocator.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_allocator_pkg.sv
// Shared definitions for the convolution window allocator: FSM encoding and window sizing.
package conv_allocator_pkg;

   localparam int unsigned MAX_HALF = 3;
   localparam int unsigned MAX_SIDE = 2 * MAX_HALF + 1;
   localparam int unsigned MAX_WIN  = MAX_SIDE * MAX_SIDE;
   localparam int unsigned IDX_W    = 6;
   localparam int unsigned HALF_W   = 2;
   localparam int unsigned DEPTH_W  = 9;
   localparam int unsigned STALL_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_FULL    = 2'd2,
      ST_DRAIN   = 2'd3
   } state_e;

endpackage

// File: rtl/conv_alloc_bounds.sv
// Combinational window clipping: centre +/- h clipped to the image, plus in-image pixel count.
module conv_alloc_bounds
   import conv_allocator_pkg::*;
#(
   parameter int unsigned COORD_W = 8
) (
   input  logic [COORD_W-1:0]        cx,
   input  logic [COORD_W-1:0]        cy,
   input  logic [HALF_W-1:0]         h,
   input  logic [COORD_W-1:0]        image_dim,
   output logic signed [COORD_W+1:0] x0,
   output logic signed [COORD_W+1:0] x1,
   output logic signed [COORD_W+1:0] y0,
   output logic signed [COORD_W+1:0] y1,
   output logic [IDX_W-1:0]          exp_count
);

   localparam int unsigned SW = COORD_W + 2;
   localparam logic signed [SW-1:0] ZERO = '0;
   localparam logic signed [SW-1:0] ONE  = SW'(1);

   logic signed [SW-1:0] h_s, lim, lo_x, hi_x, lo_y, hi_y, wx, wy, area;

   assign h_s = $signed(SW'(h));
   assign lim = $signed(SW'(image_dim)) - ONE;

   always_comb begin
      lo_x = $signed(SW'(cx)) - h_s;
      hi_x = $signed(SW'(cx)) + h_s;
      lo_y = $signed(SW'(cy)) - h_s;
      hi_y = $signed(SW'(cy)) + h_s;
      x0   = lo_x[SW-1] ? ZERO : lo_x;
      y0   = lo_y[SW-1] ? ZERO : lo_y;
      x1   = (hi_x > lim) ? lim : hi_x;
      y1   = (hi_y > lim) ? lim : hi_y;
      wx   = x1 - x0 + ONE;
      wy   = y1 - y0 + ONE;
      area = wx * wy;
      exp_count = '0;
      // A centre off the image leaves an empty or negative extent
      if (!wx[SW-1] && (wx != ZERO) && !wy[SW-1] && (wy != ZERO))
         exp_count = IDX_W'(area);
   end

endmodule

// File: rtl/conv_allocator.sv
// One allocator slot: captures a (2h+1)^2 window from the Issue broadcast and streams it to the MAC.
// Optional CONV_ALLOCATOR_STATS_EN adds a saturating stall_count of issue_block cycles.
module conv_allocator
   import conv_allocator_pkg::*;
#(
   parameter int unsigned DATA_W  = 18,
   parameter int unsigned COORD_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COORD_W-1:0] image_dim,
   input  logic [DEPTH_W-1:0] image_depth,
   input  logic [HALF_W-1:0]  filter_halfsize,
   input  logic               positioner_sel,
   input  logic [COORD_W-1:0] positioner_x,
   input  logic [COORD_W-1:0] positioner_y,
   input  logic [COORD_W-1:0] issue_x,
   input  logic [COORD_W-1:0] issue_y,
   input  logic [DATA_W-1:0]  issue_data,
   input  logic               issue_en,
   output logic               issue_block,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [IDX_W-1:0]   out_idx,
   output logic               out_last,
   output logic               busy,
   output logic               done
`ifdef CONV_ALLOCATOR_STATS_EN
   ,
   output logic [STALL_W-1:0] stall_count
`endif
);

   localparam int unsigned SW = COORD_W + 2;

   state_e                state;
   logic signed [SW-1:0]  cx_q, cy_q, x0_q, x1_q, y0_q, y1_q;
   logic [HALF_W-1:0]     h_q;
   logic [IDX_W-1:0]      exp_q, cnt_q;
   logic [DEPTH_W-1:0]    ch_q;
   logic [MAX_WIN-1:0]    valid_q;
   logic [DATA_W-1:0]     win_mem [MAX_WIN];

   logic signed [SW-1:0]  b_x0, b_x1, b_y0, b_y1;
   logic [IDX_W-1:0]      b_exp;
   logic signed [SW-1:0]  pos_x_s, pos_y_s, ix_s, iy_s, dx_s, dy_s;
   logic [2:0]            side_c;
   logic [IDX_W-1:0]      last_idx_c, slot_c, cnt_nxt_c, idx_nxt_c;
   logic [DEPTH_W-1:0]    depth_eff_c, ch_nxt_c;
   logic                  hit_c, new_c, hs_c;

   conv_alloc_bounds #(.COORD_W(COORD_W)) u_bounds (
      .cx        (positioner_x),
      .cy        (positioner_y),
      .h         (filter_halfsize),
      .image_dim (image_dim),
      .x0        (b_x0),
      .x1        (b_x1),
      .y0        (b_y0),
      .y1        (b_y1),
      .exp_count (b_exp)
   );

   // Marks window slots that fall outside the image; they are served as zero padding
   function automatic logic [MAX_WIN-1:0] pad_mask(
      input logic signed [SW-1:0] cx, cy, x0, x1, y0, y1,
      input logic [HALF_W-1:0]    h
   );
      logic [MAX_WIN-1:0] m;
      int side, px, py;
      m    = '0;
      side = 2 * int'(h) + 1;
      for (int r = 0; r < int'(MAX_SIDE); r++) begin
         for (int c = 0; c < int'(MAX_SIDE); c++) begin
            px = int'(cx) - int'(h) + c;
            py = int'(cy) - int'(h) + r;
            if ((r < side) && (c < side) &&
                ((px < int'(x0)) || (px > int'(x1)) || (py < int'(y0)) || (py > int'(y1))))
               m[IDX_W'(r * side + c)] = 1'b1;
         end
      end
      return m;
   endfunction

   assign pos_x_s     = $signed(SW'(positioner_x));
   assign pos_y_s     = $signed(SW'(positioner_y));
   assign ix_s        = $signed(SW'(issue_x));
   assign iy_s        = $signed(SW'(issue_y));
   assign dx_s        = ix_s - cx_q + $signed(SW'(h_q));
   assign dy_s        = iy_s - cy_q + $signed(SW'(h_q));
   assign side_c      = {h_q, 1'b1};
   assign last_idx_c  = IDX_W'(side_c) * IDX_W'(side_c) - IDX_W'(1);
   assign hit_c       = issue_en && (ix_s >= x0_q) && (ix_s <= x1_q) &&
                        (iy_s >= y0_q) && (iy_s <= y1_q);
   assign slot_c      = IDX_W'(dy_s[2:0]) * IDX_W'(side_c) + IDX_W'(dx_s[2:0]);
   assign new_c       = hit_c && !valid_q[slot_c];
   assign cnt_nxt_c   = cnt_q + IDX_W'(new_c);
   assign idx_nxt_c   = out_idx + IDX_W'(1);
   assign hs_c        = out_valid && out_ready;
   assign depth_eff_c = (image_depth == '0) ? DEPTH_W'(1) : image_depth;
   assign ch_nxt_c    = ch_q + DEPTH_W'(1);

   // Stall Issue while the buffer holds a window that has not been handed off
   assign issue_block = hit_c && ((state == ST_FULL) || (state == ST_DRAIN));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         cx_q      <= '0;
         cy_q      <= '0;
         x0_q      <= '0;
         x1_q      <= '0;
         y0_q      <= '0;
         y1_q      <= '0;
         h_q       <= '0;
         exp_q     <= '0;
         cnt_q     <= '0;
         ch_q      <= '0;
         valid_q   <= '0;
         for (int i = 0; i < int'(MAX_WIN); i++) win_mem[i] <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (positioner_sel) begin
                  cx_q    <= pos_x_s;
                  cy_q    <= pos_y_s;
                  h_q     <= filter_halfsize;
                  x0_q    <= b_x0;
                  x1_q    <= b_x1;
                  y0_q    <= b_y0;
                  y1_q    <= b_y1;
                  exp_q   <= b_exp;
                  cnt_q   <= '0;
                  ch_q    <= '0;
                  valid_q <= pad_mask(pos_x_s, pos_y_s, b_x0, b_x1, b_y0, b_y1, filter_halfsize);
                  for (int i = 0; i < int'(MAX_WIN); i++) win_mem[i] <= '0;
                  busy    <= 1'b1;
                  state   <= ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (hit_c) begin
                  win_mem[slot_c] <= issue_data;
                  valid_q[slot_c] <= 1'b1;
               end
               cnt_q <= cnt_nxt_c;
               if (cnt_nxt_c == exp_q) state <= ST_FULL;
            end
            ST_FULL: begin
               out_valid <= 1'b1;
               out_idx   <= '0;
               out_data  <= win_mem[0];
               out_last  <= (last_idx_c == '0);
               state     <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (hs_c) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_idx   <= '0;
                     out_data  <= '0;
                     ch_q      <= ch_nxt_c;
                     cnt_q     <= '0;
                     for (int i = 0; i < int'(MAX_WIN); i++) win_mem[i] <= '0;
                     if (ch_nxt_c >= depth_eff_c) begin
                        valid_q <= '0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                     end else begin
                        valid_q <= pad_mask(cx_q, cy_q, x0_q, x1_q, y0_q, y1_q, h_q);
                        state   <= ST_COLLECT;
                     end
                  end else begin
                     out_idx  <= idx_nxt_c;
                     out_data <= win_mem[idx_nxt_c];
                     out_last <= (idx_nxt_c == last_idx_c);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef CONV_ALLOCATOR_STATS_EN
   // Saturating count of cycles Issue was held off; restarts with each new window
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_count <= '0;
      else if ((state == ST_IDLE) && positioner_sel)
         stall_count <= '0;
      else if (issue_block && (stall_count != '1))
         stall_count <= stall_count + STALL_W'(1);
   end
`endif

endmodule

// File: tb/tb_conv_allocator.sv
// Directed bench for conv_allocator: capture, clipping, back-pressure, multi-channel and async reset.
module tb_conv_allocator;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  image_dim = 8'd46;
   logic [8:0]  image_depth = 9'd1;
   logic [1:0]  filter_halfsize = 2'd1;
   logic        positioner_sel = 1'b0;
   logic [7:0]  positioner_x = '0, positioner_y = '0;
   logic [7:0]  issue_x = '0, issue_y = '0;
   logic [17:0] issue_data = '0;
   logic        issue_en = 1'b0;
   logic        issue_block;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [17:0] out_data;
   logic [5:0]  out_idx;
   logic        out_last;
   logic        busy;
   logic        done;
`ifdef CONV_ALLOCATOR_STATS_EN
   logic [15:0] stall_count;
`endif

   int n_vec = 0;
   int n_err = 0;
   int last_hs = 0;
   int elems = 0;
   int exp_d [49];

   conv_allocator dut (
      .clk             (clk),
      .rst             (rst),
      .image_dim       (image_dim),
      .image_depth     (image_depth),
      .filter_halfsize (filter_halfsize),
      .positioner_sel  (positioner_sel),
      .positioner_x    (positioner_x),
      .positioner_y    (positioner_y),
      .issue_x         (issue_x),
      .issue_y         (issue_y),
      .issue_data      (issue_data),
      .issue_en        (issue_en),
      .issue_block     (issue_block),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_idx         (out_idx),
      .out_last        (out_last),
      .busy            (busy),
      .done            (done)
`ifdef CONV_ALLOCATOR_STATS_EN
      ,
      .stall_count     (stall_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic position(input int x, input int y, input int h);
      @(negedge clk);
      positioner_sel  = 1'b1;
      positioner_x    = 8'(x);
      positioner_y    = 8'(y);
      filter_halfsize = 2'(h);
      @(posedge clk);
      #1 positioner_sel = 1'b0;
   endtask

   // Holds the broadcast until issue_block drops, then lets one edge capture it
   task automatic bcast(input int x, input int y, input int d);
      int n;
      @(negedge clk);
      issue_x    = 8'(x);
      issue_y    = 8'(y);
      issue_data = 18'(d);
      issue_en   = 1'b1;
      #1;
      n = 0;
      while (issue_block && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 200) chk("bcast_timeout", 1, 0);
      @(posedge clk);
      #1 issue_en = 1'b0;
   endtask

   task automatic bcast_win(input int base, input int skip);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            if (r * 3 + c != skip) bcast(9 + c, 9 + r, base + (9 + r) * 64 + 9 + c);
   endtask

   task automatic fill(input int base);
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            exp_d[r * 3 + c] = base + (9 + r) * 64 + 9 + c;
   endtask

   task automatic drain(input string tag, input int n, input logic exp_done);
      int guard;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         out_ready = 1'b1;
         guard = 0;
         while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
         end
         chk($sformatf("%s_valid%0d", tag, i), 32'(out_valid), 1);
         chk($sformatf("%s_idx%0d", tag, i), 32'(out_idx), 32'(i));
         chk($sformatf("%s_data%0d", tag, i), 32'(out_data), 32'(exp_d[i]));
         chk($sformatf("%s_last%0d", tag, i), 32'(out_last), 32'(i == n - 1));
         if (out_valid) elems++;
         if (out_valid && out_last) last_hs++;
         @(posedge clk);
      end
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_done"}, 32'(done), 32'(exp_done));
      chk({tag, "_busy"}, 32'(busy), 32'(!exp_done));
   endtask

   initial begin
      int guard;
      // Reset state
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_idx", 32'(out_idx), 0);
      chk("rst_last", 32'(out_last), 0);
      chk("rst_block", 32'(issue_block), 0);
      @(negedge clk);
      rst = 1'b1;

      // Centre window, single channel
      position(10, 10, 1);
      chk("t1_busy", 32'(busy), 1);
      bcast_win(0, -1);
      @(negedge clk);
      chk("t1_lat_full", 32'(out_valid), 0);
      @(negedge clk);
      chk("t1_lat_valid", 32'(out_valid), 1);
      fill(0);
      drain("t1", 9, 1'b1);

      // Corner clipping, depth 0 treated as one channel
      image_depth = 9'd0;
      position(0, 0, 1);
      bcast(0, 0, 1000);
      bcast(1, 0, 1001);
      bcast(0, 1, 1064);
      bcast(1, 1, 1065);
      @(negedge clk);
      chk("t2_lat_full", 32'(out_valid), 0);
      exp_d[0] = 0; exp_d[1] = 0; exp_d[2] = 0; exp_d[3] = 0;
      exp_d[4] = 1000; exp_d[5] = 1001; exp_d[6] = 0;
      exp_d[7] = 1064; exp_d[8] = 1065;
      drain("t2", 9, 1'b1);

      // Three channels with duplicate, back-pressure and ignored repositioning
      image_depth = 9'd3;
      last_hs = 0;
      elems = 0;
      position(10, 10, 1);
      bcast(9, 9, 7777);
      bcast_win(0, 8);
      @(negedge clk);
      @(negedge clk);
      chk("t3_dup_nofull", 32'(out_valid), 0);
      chk("t3_dup_busy", 32'(busy), 1);
      bcast(11, 11, 715);
      guard = 0;
      while (!out_valid && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("t3_held_valid", 32'(out_valid), 1);
      chk("t3_dup_data", 32'(out_data), 585);
      @(negedge clk);
      issue_x = 8'd20; issue_y = 8'd20; issue_data = 18'd1;
      issue_en = 1'b1;
      positioner_sel = 1'b1; positioner_x = 8'd30; positioner_y = 8'd30;
      #1 chk("t3_outwin_block", 32'(issue_block), 0);
      @(posedge clk);
      #1;
      issue_en = 1'b0;
      positioner_sel = 1'b0;
      @(negedge clk);
      chk("t3_stall_valid", 32'(out_valid), 1);
      chk("t3_stall_idx", 32'(out_idx), 0);
      chk("t3_stall_data", 32'(out_data), 585);
      issue_x = 8'd10; issue_y = 8'd10; issue_data = 18'd1650;
      issue_en = 1'b1;
      #1 chk("t3_inwin_block", 32'(issue_block), 1);
      fill(0);
      fork
         bcast(10, 10, 1650);
         drain("t3c0", 9, 1'b0);
      join
      bcast_win(1000, 4);
      fill(1000);
      drain("t3c1", 9, 1'b0);
      bcast_win(2000, -1);
      fill(2000);
      drain("t3c2", 9, 1'b1);
      chk("t3_last_count", 32'(last_hs), 3);
      chk("t3_elem_count", 32'(elems), 27);

      // Asynchronous reset mid-collect, then a clean restart
      image_depth = 9'd1;
      position(10, 10, 1);
      bcast(9, 9, 5);
      bcast(10, 9, 6);
      bcast(11, 9, 7);
      @(negedge clk);
      issue_x = 8'd10; issue_y = 8'd10; issue_en = 1'b1;
      #3 rst = 1'b0;
      #1;
      chk("t4_rst_busy", 32'(busy), 0);
      chk("t4_rst_valid", 32'(out_valid), 0);
      chk("t4_rst_block", 32'(issue_block), 0);
      chk("t4_rst_done", 32'(done), 0);
      @(negedge clk);
      issue_en = 1'b0;
      rst = 1'b1;
      position(10, 10, 1);
      bcast_win(3000, -1);
      fill(3000);
      drain("t4", 9, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
